// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: conditions hps_io joystick words into per-player arcade button levels,
//   with frame-synchronous coin pulses fed from a 3-entry credit queue and per-player autofire.
// Latency: 2 cycles joystick_in -> btn_*; coin start and autofire toggles land 1 cycle after a frame tick.
// Backpressure: none, free-running; coin presses arriving while 3 credits are queued are dropped.
// Ports: clk, reset_n (async, active-low), vblank (rising edge = frame tick),
//   joystick_in (16 bits per joystick: 0 R,1 L,2 D,3 U,4 fire,5 barrier,6 start1,7 start2,8 coin),
//   cocktail (1 = joystick k drives player k), autofire_en/autofire_rate,
//   btn_* per-player outputs, btn_player_start, btn_coin. All outputs registered.
module arcade_input_mapper #(
  parameter int NUM_PLAYERS     = 2,
  parameter int COIN_FRAMES     = 4,
  parameter int COIN_GAP_FRAMES = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      vblank,
  input  logic [16*NUM_PLAYERS-1:0] joystick_in,
  input  logic                      cocktail,
  input  logic [NUM_PLAYERS-1:0]    autofire_en,
  input  logic [1:0]                autofire_rate,
  output logic [NUM_PLAYERS-1:0]    btn_left,
  output logic [NUM_PLAYERS-1:0]    btn_right,
  output logic [NUM_PLAYERS-1:0]    btn_up,
  output logic [NUM_PLAYERS-1:0]    btn_down,
  output logic [NUM_PLAYERS-1:0]    btn_fire,
  output logic [NUM_PLAYERS-1:0]    btn_barrier,
  output logic [NUM_PLAYERS-1:0]    btn_player_start,
  output logic                      btn_coin
);

  localparam logic [3:0] PULSE_TICKS = 4'(COIN_FRAMES);
  localparam logic [3:0] GAP_TICKS   = 4'(COIN_GAP_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } coin_state_t;

  logic [16*NUM_PLAYERS-1:0] r_joy;
  logic                      r_vblank_d;
  logic                      r_coin_d;
  logic [1:0]                r_credits;
  coin_state_t               r_state;
  logic [3:0]                r_frame_cnt;
  logic [NUM_PLAYERS-1:0]    r_fire_d;
  logic [NUM_PLAYERS-1:0]    r_af_phase;
  logic [1:0]                r_af_cnt [NUM_PLAYERS];

  logic [15:0] w_any;
  logic [15:0] w_route [NUM_PLAYERS];
  logic        w_tick;
  logic        w_coin_edge;
  logic        w_gap_done;
  logic        w_coin_take;

  // Merged view of every joystick; used for upright routing, start buttons and coin.
  always_comb begin
    w_any = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      w_any = w_any | r_joy[16*k +: 16];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      w_route[k] = cocktail ? r_joy[16*k +: 16] : w_any;
    end
  end

  assign w_tick      = vblank & ~r_vblank_d;
  assign w_coin_edge = w_any[8] & ~r_coin_d;
  assign w_gap_done  = (r_state == S_GAP) && w_tick && ((r_frame_cnt + 4'd1) == GAP_TICKS);
  // A queued credit starts a pulse on a tick from IDLE, or on the very tick the gap
  // completes, so back-to-back credits are spaced by exactly the gap length.
  assign w_coin_take = w_tick && (r_credits != 2'd0) && ((r_state == S_IDLE) || w_gap_done);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_joy      <= '0;
      r_vblank_d <= 1'b0;
      r_coin_d   <= 1'b0;
    end else begin
      r_joy      <= joystick_in;
      r_vblank_d <= vblank;
      r_coin_d   <= w_any[8];
    end
  end

  // Direction, barrier and start outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_left         <= '0;
      btn_right        <= '0;
      btn_up           <= '0;
      btn_down         <= '0;
      btn_barrier      <= '0;
      btn_player_start <= '0;
    end else begin
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        btn_right[k]   <= w_route[k][0];
        btn_left[k]    <= w_route[k][1];
        btn_down[k]    <= w_route[k][2];
        btn_up[k]      <= w_route[k][3];
        btn_barrier[k] <= w_route[k][5];
        // Players 1 and 2 accept their start from any joystick; higher players
        // only from their own joystick's start1.
        if (k == 0) begin
          btn_player_start[k] <= w_any[6];
        end else if (k == 1) begin
          btn_player_start[k] <= w_any[7];
        end else begin
          btn_player_start[k] <= r_joy[16*k+6];
        end
      end
    end
  end

  // Credit queue and coin pulse shaper.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_credits   <= 2'd0;
      r_state     <= S_IDLE;
      r_frame_cnt <= 4'd0;
      btn_coin    <= 1'b0;
    end else begin
      case ({w_coin_edge, w_coin_take})
        2'b10: if (r_credits != 2'd3) r_credits <= r_credits + 2'd1;
        2'b01: r_credits <= r_credits - 2'd1;
        default: r_credits <= r_credits;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_coin_take) begin
            r_state     <= S_PULSE;
            btn_coin    <= 1'b1;
            r_frame_cnt <= 4'd0;
          end
        end
        S_PULSE: begin
          if (w_tick) begin
            if ((r_frame_cnt + 4'd1) == PULSE_TICKS) begin
              r_state     <= S_GAP;
              btn_coin    <= 1'b0;
              r_frame_cnt <= 4'd0;
            end else begin
              r_frame_cnt <= r_frame_cnt + 4'd1;
            end
          end
        end
        S_GAP: begin
          if (w_gap_done) begin
            r_frame_cnt <= 4'd0;
            if (w_coin_take) begin
              r_state  <= S_PULSE;
              btn_coin <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_tick) begin
            r_frame_cnt <= r_frame_cnt + 4'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          btn_coin <= 1'b0;
        end
      endcase
    end
  end

  // Autofire: phase starts high on the press, toggles every autofire_rate+1 ticks
  // while held, and is cleared on release so the next press starts high again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fire_d   <= '0;
      r_af_phase <= '0;
      btn_fire   <= '0;
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        r_af_cnt[k] <= 2'd0;
      end
    end else begin
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        r_fire_d[k] <= w_route[k][4];
        if (!w_route[k][4]) begin
          r_af_phase[k] <= 1'b0;
          r_af_cnt[k]   <= 2'd0;
          btn_fire[k]   <= 1'b0;
        end else if (!r_fire_d[k]) begin
          r_af_phase[k] <= 1'b1;
          r_af_cnt[k]   <= 2'd0;
          btn_fire[k]   <= 1'b1;
        end else if (w_tick && (r_af_cnt[k] == autofire_rate)) begin
          r_af_phase[k] <= ~r_af_phase[k];
          r_af_cnt[k]   <= 2'd0;
          btn_fire[k]   <= ~autofire_en[k] | ~r_af_phase[k];
        end else begin
          if (w_tick) r_af_cnt[k] <= r_af_cnt[k] + 2'd1;
          btn_fire[k] <= ~autofire_en[k] | r_af_phase[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: 4 players, 4-frame coin pulse, 4-frame gap.
// Frames are 20 clocks long (vblank high for 5); inputs change on the falling clock edge.
module tb_arcade_input_mapper;

  localparam int NP = 4;
  localparam int CF = 4;
  localparam int CG = 4;
  localparam int FRAME = 20;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            vblank;
  logic [16*NP-1:0] joystick_in;
  logic            cocktail;
  logic [NP-1:0]   autofire_en;
  logic [1:0]      autofire_rate;
  logic [NP-1:0]   btn_left, btn_right, btn_up, btn_down, btn_fire, btn_barrier, btn_player_start;
  logic            btn_coin;

  int total = 0;
  int bad   = 0;
  int vb_cyc = FRAME - 1;
  bit vb_on  = 1'b0;

  arcade_input_mapper #(
    .NUM_PLAYERS(NP), .COIN_FRAMES(CF), .COIN_GAP_FRAMES(CG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vblank(vblank), .joystick_in(joystick_in),
    .cocktail(cocktail), .autofire_en(autofire_en), .autofire_rate(autofire_rate),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .btn_fire(btn_fire), .btn_barrier(btn_barrier), .btn_player_start(btn_player_start),
    .btn_coin(btn_coin)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_j1 = joystick word seen one edge ago, m_j2 = two edges ago.
  // Coin: pulses are placed on a frame-tick timeline (tick index m_f); a pulse
  // started at tick S is high until tick S+CF and the next may start at S+CF+CG.
  // Autofire: output phase = even number of completed (rate+1)-tick intervals.
  logic [16*NP-1:0] m_j1, m_j2;
  logic             m_vb, m_started;
  int               m_credits, m_f, m_last;
  int               m_n [NP];
  logic [NP-1:0]    m_fprev;
  logic [NP-1:0]    e_left, e_right, e_up, e_down, e_fire, e_bar, e_start;
  logic             e_coin;

  logic [15:0]   c_any, c_any2, c_rt;
  logic          c_tick, c_take, c_started, c_coin;
  int            c_f, c_last, c_cr;
  int            c_n [NP];
  logic [NP-1:0] c_left, c_right, c_up, c_down, c_fire, c_bar, c_start, c_fprev;

  always_comb begin
    c_any = 16'h0; c_any2 = 16'h0; c_rt = 16'h0;
    c_left = '0; c_right = '0; c_up = '0; c_down = '0;
    c_fire = '0; c_bar = '0; c_start = '0; c_fprev = '0;
    for (int k = 0; k < NP; k++) c_n[k] = m_n[k];
    c_tick = vblank && !m_vb;
    for (int k = 0; k < NP; k++) begin
      c_any  = c_any  | m_j1[16*k +: 16];
      c_any2 = c_any2 | m_j2[16*k +: 16];
    end
    c_f       = m_f + (c_tick ? 1 : 0);
    c_take    = c_tick && (m_credits > 0) && (!m_started || (c_f >= m_last + CF + CG));
    c_started = m_started || c_take;
    c_last    = c_take ? c_f : m_last;
    c_cr      = m_credits + ((c_any[8] && !c_any2[8]) ? 1 : 0) - (c_take ? 1 : 0);
    if (c_cr > 3) c_cr = 3;
    c_coin    = c_started && ((c_f - c_last) < CF);
    for (int k = 0; k < NP; k++) begin
      c_rt       = cocktail ? m_j1[16*k +: 16] : c_any;
      c_right[k] = c_rt[0];
      c_left[k]  = c_rt[1];
      c_down[k]  = c_rt[2];
      c_up[k]    = c_rt[3];
      c_bar[k]   = c_rt[5];
      c_fprev[k] = c_rt[4];
      if (c_rt[4] && !m_fprev[k]) c_n[k] = 0;
      else if (c_rt[4] && c_tick) c_n[k] = m_n[k] + 1;
      c_fire[k]  = c_rt[4] && (!autofire_en[k] || (((c_n[k] / (int'(autofire_rate) + 1)) % 2) == 0));
      c_start[k] = (k == 0) ? c_any[6] : (k == 1) ? c_any[7] : m_j1[16*k+6];
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_j1 <= '0; m_j2 <= '0; m_vb <= 1'b0; m_started <= 1'b0;
      m_credits <= 0; m_f <= 0; m_last <= 0; m_fprev <= '0;
      for (int k = 0; k < NP; k++) m_n[k] <= 0;
      e_left <= '0; e_right <= '0; e_up <= '0; e_down <= '0;
      e_fire <= '0; e_bar <= '0; e_start <= '0; e_coin <= 1'b0;
    end else begin
      m_j1 <= joystick_in; m_j2 <= m_j1; m_vb <= vblank; m_started <= c_started;
      m_credits <= c_cr; m_f <= c_f; m_last <= c_last; m_fprev <= c_fprev;
      for (int k = 0; k < NP; k++) m_n[k] <= c_n[k];
      e_left <= c_left; e_right <= c_right; e_up <= c_up; e_down <= c_down;
      e_fire <= c_fire; e_bar <= c_bar; e_start <= c_start; e_coin <= c_coin;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_left",    32'(btn_left),         32'(e_left));
    chk("m_right",   32'(btn_right),        32'(e_right));
    chk("m_up",      32'(btn_up),           32'(e_up));
    chk("m_down",    32'(btn_down),         32'(e_down));
    chk("m_barrier", 32'(btn_barrier),      32'(e_bar));
    chk("m_fire",    32'(btn_fire),         32'(e_fire));
    chk("m_start",   32'(btn_player_start), 32'(e_start));
    chk("m_coin",    32'(btn_coin),         32'(e_coin));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    if (vb_on) begin
      vb_cyc = (vb_cyc == FRAME - 1) ? 0 : vb_cyc + 1;
      vblank = (vb_cyc < 5);
    end else begin
      vblank = 1'b0;
    end
  endtask

  task automatic wait_vb(input int v);
    int n;
    n = 0;
    while (vb_cyc != v && n < 2 * FRAME) begin
      step();
      n++;
    end
  endtask

  task automatic coin_tap(input int j);
    joystick_in[16*j+8] = 1'b1;
    step();
    joystick_in[16*j+8] = 1'b0;
    step();
  endtask

  int obs_nr;
  int obs_rise [8];
  int obs_fall [8];

  task automatic observe(input int cycles);
    logic prev;
    int   nf;
    prev = 1'b0;
    obs_nr = 0;
    nf = 0;
    for (int i = 0; i < 8; i++) begin
      obs_rise[i] = 0;
      obs_fall[i] = 0;
    end
    for (int i = 0; i < cycles; i++) begin
      step();
      if (btn_coin && !prev) begin
        if (obs_nr < 8) obs_rise[obs_nr] = i;
        obs_nr++;
      end
      if (!btn_coin && prev) begin
        if (nf < 8) obs_fall[nf] = i;
        nf++;
      end
      prev = btn_coin;
    end
  endtask

  logic [9:0] af_exp;
  logic [9:0] af_got;
  int         n_wait;

  initial begin
    reset_n = 1'b0; vblank = 1'b0; joystick_in = '0; cocktail = 1'b0;
    autofire_en = '0; autofire_rate = 2'd0;
    repeat (3) step();
    #2 reset_n = 1'b1;
    step();
    chk("reset_coin",  32'(btn_coin), 32'd0);
    chk("reset_left",  32'(btn_left), 32'd0);
    chk("reset_start", 32'(btn_player_start), 32'd0);

    // Routing: merged, then cocktail.
    joystick_in[16+1] = 1'b1;
    step();
    chk("route_latency1", 32'(btn_left), 32'd0);
    step();
    chk("route_merged", 32'(btn_left), 32'(4'b1111));
    cocktail = 1'b1;
    step();
    chk("route_cocktail", 32'(btn_left), 32'(4'b0010));
    joystick_in = '0;
    cocktail = 1'b0;
    repeat (2) step();

    // Start routing.
    cocktail = 1'b1;
    joystick_in[7] = 1'b1;
    repeat (2) step();
    chk("start_p2", 32'(btn_player_start), 32'(4'b0010));
    joystick_in[48+6] = 1'b1;
    repeat (2) step();
    chk("start_p4", 32'(btn_player_start), 32'(4'b1011));
    joystick_in = '0;
    cocktail = 1'b0;
    repeat (2) step();

    // Coin queue: four edges within one frame, only three credits fit.
    vb_on = 1'b1;
    wait_vb(8);
    coin_tap(0); coin_tap(1); coin_tap(2); coin_tap(3);
    observe(40 * FRAME);
    chk("queue_npulse", 32'(obs_nr), 32'd3);
    for (int i = 0; i < 3; i++) chk("queue_width", 32'(obs_fall[i] - obs_rise[i]), 32'(CF * FRAME));
    for (int i = 0; i < 2; i++) chk("queue_gap", 32'(obs_rise[i+1] - obs_fall[i]), 32'(CG * FRAME));

    // Coin edge landing on the IDLE->PULSE tick with one credit queued.
    wait_vb(10);
    coin_tap(0);
    wait_vb(FRAME - 1);
    joystick_in[16+8] = 1'b1;
    step();
    joystick_in[16+8] = 1'b0;
    observe(25 * FRAME);
    chk("simul_npulse", 32'(obs_nr), 32'd2);
    chk("simul_spacing", 32'(obs_rise[1] - obs_rise[0]), 32'((CF + CG) * FRAME));

    // Reset in the middle of a pulse with two credits still queued.
    wait_vb(10);
    coin_tap(0); coin_tap(0); coin_tap(0);
    n_wait = 0;
    while (!btn_coin && n_wait < 3 * FRAME) begin
      step();
      n_wait++;
    end
    chk("rst_pulse_seen", 32'(btn_coin), 32'd1);
    repeat (30) step();
    chk("rst_mid_pulse", 32'(btn_coin), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_coin", 32'(btn_coin), 32'd0);
    repeat (3) step();
    #2 reset_n = 1'b1;
    observe(20 * FRAME);
    chk("rst_no_pulse", 32'(obs_nr), 32'd0);

    // Autofire on player 0, rate 1: two frames high, two low.
    autofire_en = 4'b0001;
    autofire_rate = 2'd1;
    af_exp = 10'b1100110011;
    af_got = '0;
    wait_vb(8);
    joystick_in[4] = 1'b1;
    wait_vb(15);
    af_got[0] = btn_fire[0];
    chk("af_plain_p1", 32'(btn_fire[1]), 32'd1);
    for (int j = 1; j < 10; j++) begin
      step();
      wait_vb(15);
      af_got[j] = btn_fire[0];
    end
    for (int j = 0; j < 10; j++) chk("af_pattern", 32'(af_got[j]), 32'(af_exp[j]));
    joystick_in[4] = 1'b0;
    repeat (2) step();
    chk("af_release", 32'(btn_fire), 32'd0);

    // Autofire rate 0 in cocktail mode on two players.
    autofire_rate = 2'd0;
    autofire_en = 4'b0011;
    cocktail = 1'b1;
    joystick_in[4] = 1'b1;
    joystick_in[16+4] = 1'b1;
    repeat (6 * FRAME) step();
    joystick_in = '0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
